my9262_ctrl_regs: RTL and testbench

Avalon-MM slave register block for a chain of MY9262 LED drivers. It holds one grayscale word per channel and a control/status register. On a start command it streams every channel word, highest channel first, to the downstream serial shifter through a valid/ready handshake. After the last word it issues a one-cycle latch pulse. It sits between the Avalon interconnect and the MY9262 shift/latch driver. It replaces the single-word data register with its bare start strobe.

---
 rtl/my9262_pkg.sv | 30 +++
 rtl/my9262_seq.sv | 64 ++++++
 rtl/my9262_ctrl_regs.sv | 111 +++++++++++
 tb/tb_my9262_ctrl_regs.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/my9262_pkg.sv
// Shared definitions for the MY9262 control register block: address map,
// CTRL/STATUS bit positions and the frame sequencer state encoding.
package my9262_pkg;

  localparam int OFF_CTRL    = 0;
  localparam int OFF_INFO    = 1;
  localparam int OFF_CH_BASE = 2;

  // CTRL write bits
  localparam int BIT_START    = 0;
  localparam int BIT_CLR_DONE = 1;
  localparam int BIT_CLR_OVR  = 2;
  localparam int BIT_IRQ_EN   = 3;

  // STATUS read bits
  localparam int BIT_BUSY = 0;
  localparam int BIT_DONE = 1;
  localparam int BIT_OVR  = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SEND  = 2'd1,
    ST_LATCH = 2'd2
  } seq_state_e;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/my9262_seq.sv
// Frame sequencer: walks the channel array from the top index down through a
// valid/ready handshake, then issues a one-cycle latch pulse.
module my9262_seq
  import my9262_pkg::*;
#(
  parameter int CHANNELS = 16,
  parameter int DATA_W   = 16,
  parameter int IDX_W    = idx_width(CHANNELS)
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             start,
  input  logic [CHANNELS-1:0][DATA_W-1:0]  chan,
  output logic [DATA_W-1:0]                coe_data,
  output logic                             coe_valid,
  input  logic                             coe_ready,
  output logic                             coe_latch,
  output logic                             done_set,
  output logic                             busy
);

  seq_state_e       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_SEND;
          idx_d   = IDX_W'(CHANNELS - 1);
        end
      end
      ST_SEND: begin
        if (coe_ready) begin
          if (idx_q == '0) state_d = ST_LATCH;
          else             idx_d   = idx_q - 1'b1;
        end
      end
      ST_LATCH: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Data is read live from the array so a channel rewritten before its turn
  // goes out with the new value; it is forced to zero outside SEND.
  assign coe_valid = (state_q == ST_SEND);
  assign coe_data  = coe_valid ? chan[idx_q] : '0;
  assign coe_latch = (state_q == ST_LATCH);
  assign done_set  = coe_latch;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: rtl/my9262_ctrl_regs.sv
// Avalon-MM register block for a chain of MY9262 LED drivers: channel words,
// CTRL/STATUS, and a frame sequencer. Optional MY9262_IRQ_EN adds the IRQ_EN bit.
module my9262_ctrl_regs
  import my9262_pkg::*;
#(
  parameter int CHANNELS = 16,
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 5
) (
  input  logic              csi_clk,
  input  logic              rsi_reset_n,
  input  logic [ADDR_W-1:0] avs_address,
  input  logic              avs_write,
  input  logic [31:0]       avs_writedata,
  input  logic              avs_read,
  output logic [31:0]       avs_readdata,
  output logic [DATA_W-1:0] coe_data,
  output logic              coe_valid,
  input  logic              coe_ready,
  output logic              coe_latch,
  output logic              ins_irq
);

  logic [CHANNELS-1:0][DATA_W-1:0] chan_q;
  logic        done_q, ovr_q, irq_en;
  logic        wr_ctrl, start_req, busy, done_set;
  logic [31:0] rd_mux;
  logic        unused_wdata;

  assign wr_ctrl   = avs_write && (avs_address == ADDR_W'(OFF_CTRL));
  assign start_req = wr_ctrl && avs_writedata[BIT_START];
  assign unused_wdata = ^avs_writedata;

  always_ff @(posedge csi_clk or negedge rsi_reset_n) begin
    if (!rsi_reset_n) begin
      chan_q <= '0;
    end else begin
      for (int n = 0; n < CHANNELS; n++) begin
        if (avs_write && (avs_address == ADDR_W'(OFF_CH_BASE + n)))
          chan_q[n] <= avs_writedata[DATA_W-1:0];
      end
    end
  end

  // Sticky bits: a set in the same cycle as its clear wins.
  always_ff @(posedge csi_clk or negedge rsi_reset_n) begin
    if (!rsi_reset_n) begin
      done_q <= 1'b0;
      ovr_q  <= 1'b0;
    end else begin
      if (done_set)                                done_q <= 1'b1;
      else if (wr_ctrl && avs_writedata[BIT_CLR_DONE]) done_q <= 1'b0;
      if (start_req && busy)                       ovr_q  <= 1'b1;
      else if (wr_ctrl && avs_writedata[BIT_CLR_OVR])  ovr_q  <= 1'b0;
    end
  end

`ifdef MY9262_IRQ_EN
  logic irq_en_q;

  always_ff @(posedge csi_clk or negedge rsi_reset_n) begin
    if (!rsi_reset_n)  irq_en_q <= 1'b0;
    else if (wr_ctrl)  irq_en_q <= avs_writedata[BIT_IRQ_EN];
  end

  assign irq_en  = irq_en_q;
  assign ins_irq = done_q && irq_en_q;
`else
  assign irq_en  = 1'b0;
  assign ins_irq = 1'b0;
`endif

  always_comb begin
    rd_mux = '0;
    if (avs_address == ADDR_W'(OFF_CTRL)) begin
      rd_mux[BIT_BUSY]   = busy;
      rd_mux[BIT_DONE]   = done_q;
      rd_mux[BIT_OVR]    = ovr_q;
      rd_mux[BIT_IRQ_EN] = irq_en;
    end else if (avs_address == ADDR_W'(OFF_INFO)) begin
      rd_mux = 32'(CHANNELS);
    end else begin
      for (int n = 0; n < CHANNELS; n++) begin
        if (avs_address == ADDR_W'(OFF_CH_BASE + n))
          rd_mux = 32'(chan_q[n]);
      end
    end
  end

  always_ff @(posedge csi_clk or negedge rsi_reset_n) begin
    if (!rsi_reset_n)   avs_readdata <= '0;
    else if (avs_read)  avs_readdata <= rd_mux;
  end

  my9262_seq #(
    .CHANNELS (CHANNELS),
    .DATA_W   (DATA_W)
  ) u_seq (
    .clk       (csi_clk),
    .rst_n     (rsi_reset_n),
    .start     (start_req),
    .chan      (chan_q),
    .coe_data  (coe_data),
    .coe_valid (coe_valid),
    .coe_ready (coe_ready),
    .coe_latch (coe_latch),
    .done_set  (done_set),
    .busy      (busy)
  );

endmodule

// File: tb/tb_my9262_ctrl_regs.sv
// Scoreboard bench for my9262_ctrl_regs: stimulus pushes expected words, reads
// and latch pulses; a negedge monitor pops and compares.
module tb_my9262_ctrl_regs;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [4:0]  avs_address = '0;
  logic        avs_write = 1'b0;
  logic [31:0] avs_writedata = '0;
  logic        avs_read = 1'b0;
  logic [31:0] avs_readdata;
  logic [15:0] coe_data;
  logic        coe_valid;
  logic        coe_ready = 1'b0;
  logic        coe_latch;
  logic        ins_irq;

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_q[$];
  logic [31:0] rd_q[$];
  int exp_latch = 0;
  int latch_cnt = 0;
  int ready_mode = 0;
  logic [15:0] model[16];
  logic        rd_fire = 1'b0;
  logic        stall = 1'b0;
  logic [15:0] stall_data = '0;

  my9262_ctrl_regs dut (
    .csi_clk       (clk),
    .rsi_reset_n   (rst_n),
    .avs_address   (avs_address),
    .avs_write     (avs_write),
    .avs_writedata (avs_writedata),
    .avs_read      (avs_read),
    .avs_readdata  (avs_readdata),
    .coe_data      (coe_data),
    .coe_valid     (coe_valid),
    .coe_ready     (coe_ready),
    .coe_latch     (coe_latch),
    .ins_irq       (ins_irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: event seen with nothing expected", name);
  endtask

  // coe_ready driver: 0 low, 1 high, 2 random
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       coe_ready = 1'b0;
      1:       coe_ready = 1'b1;
      default: coe_ready = 1'($urandom_range(0, 1));
    endcase
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      rd_fire = 1'b0;
      stall   = 1'b0;
    end else begin
      if (rd_fire) begin
        if (rd_q.size() == 0) fail("read_unexpected");
        else chk("readdata", avs_readdata, rd_q.pop_front());
      end
      rd_fire = avs_read;
      if (stall) begin
        chk("stall_valid", 32'(coe_valid), 32'd1);
        chk("stall_data", 32'(coe_data), 32'(stall_data));
      end
      stall      = coe_valid && !coe_ready;
      stall_data = coe_data;
      if (coe_valid && coe_ready) begin
        if (exp_q.size() == 0) fail("word_unexpected");
        else chk("coe_data", 32'(coe_data), 32'(exp_q.pop_front()));
      end
      if (coe_latch) begin
        latch_cnt++;
        if (exp_latch == 0) fail("latch_unexpected");
        else exp_latch--;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int addr, input logic [31:0] data);
    avs_address   = 5'(addr);
    avs_writedata = data;
    avs_write     = 1'b1;
    tick();
    avs_write     = 1'b0;
  endtask

  task automatic rd(input int addr, input logic [31:0] exp);
    rd_q.push_back(exp);
    avs_address = 5'(addr);
    avs_read    = 1'b1;
    tick();
    avs_read    = 1'b0;
  endtask

  task automatic start_frame(input logic [31:0] ctrl);
    for (int i = 15; i >= 0; i--) exp_q.push_back(model[i]);
    exp_latch++;
    wr(0, ctrl);
  endtask

  task automatic wait_frame(input int maxc);
    int c0 = latch_cnt;
    int n  = 0;
    while (latch_cnt == c0 && n < maxc) begin
      tick();
      n++;
    end
    chk("frame_done", 32'(latch_cnt != c0), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: actual timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int lc;
    for (int i = 0; i < 16; i++) model[i] = '0;

    // reset state
    #12;
    chk("rst_readdata", avs_readdata, 32'd0);
    chk("rst_valid", 32'(coe_valid), 32'd0);
    chk("rst_data", 32'(coe_data), 32'd0);
    chk("rst_latch", 32'(coe_latch), 32'd0);
    chk("rst_irq", 32'(ins_irq), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    rd(1, 32'd16);
    rd(0, 32'd0);

    // map edges: INFO read-only, out-of-range reads zero
    wr(1, 32'd5);
    rd(1, 32'd16);
    wr(18, 32'h1234);
    rd(18, 32'd0);
    rd(31, 32'd0);

    for (int n = 0; n < 16; n++) begin
      wr(2 + n, 32'h1000 + 32'(n));
      model[n] = 16'h1000 + 16'(n);
    end
    wr(5, 32'hABCD_1003);
    rd(5, 32'h0000_1003);
    rd(17, 32'h0000_100F);

    // streaming frame, ready held high
    ready_mode = 1;
    tick(); tick();
    start_frame(32'h1);
    for (int i = 0; i < 16; i++) begin
      chk("stream_valid", 32'(coe_valid), 32'd1);
      tick();
    end
    chk("stream_latch", 32'(coe_latch), 32'd1);
    tick();
    chk("busy_after_latch", 32'(coe_valid), 32'd0);
    rd(0, 32'h2);

    // random backpressure
    ready_mode = 2;
    start_frame(32'h1);
    wait_frame(400);
    rd(0, 32'h2);

    // START during frame sets OVR, frame unaffected
    start_frame(32'h1);
    tick(); tick(); tick();
    wr(0, 32'h1);
    wait_frame(400);
    rd(0, 32'h6);
    wr(0, 32'h4);
    rd(0, 32'h2);
    start_frame(32'h3);
    rd(0, 32'h1);
    wait_frame(400);
    rd(0, 32'h2);

    // CLR_DONE during LATCH loses to set; START right after LATCH accepted
    ready_mode = 1;
    tick(); tick();
    start_frame(32'h1);
    for (int i = 0; i < 16; i++) tick();
    chk("latch_cycle", 32'(coe_latch), 32'd1);
    wr(0, 32'h2);
    start_frame(32'h1);
    rd(0, 32'h3);
    wait_frame(100);
    rd(0, 32'h2);

    // channel 0 rewritten mid-frame before it is sent
    exp_latch++;
    for (int i = 15; i >= 1; i--) exp_q.push_back(model[i]);
    exp_q.push_back(16'hBEEF);
    wr(0, 32'h1);
    wr(2, 32'h0000_BEEF);
    model[0] = 16'hBEEF;
    wait_frame(100);
    rd(2, 32'h0000_BEEF);

`ifdef MY9262_IRQ_EN
    start_frame(32'hB);
    chk("irq_low_in_frame", 32'(ins_irq), 32'd0);
    wait_frame(100);
    chk("irq_after_latch", 32'(ins_irq), 32'd1);
    rd(0, 32'hA);
    wr(0, 32'hA);
    chk("irq_cleared", 32'(ins_irq), 32'd0);
`else
    start_frame(32'hB);
    wait_frame(100);
    chk("irq_tied_low", 32'(ins_irq), 32'd0);
    rd(0, 32'h2);
`endif

    // reset mid-frame
    tick(); tick();
    start_frame(32'h1);
    tick(); tick(); tick();
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", 32'(coe_valid), 32'd0);
    chk("midrst_data", 32'(coe_data), 32'd0);
    chk("midrst_latch", 32'(coe_latch), 32'd0);
    exp_q.delete();
    rd_q.delete();
    exp_latch = 0;
    lc = latch_cnt;
    for (int i = 0; i < 16; i++) model[i] = '0;
    tick(); tick();
    rst_n = 1'b1;
    for (int i = 0; i < 25; i++) tick();
    chk("midrst_no_latch", 32'(latch_cnt), 32'(lc));
    rd(0, 32'd0);
    rd(2, 32'd0);

    tick(); tick(); tick();
    chk("words_drained", 32'(exp_q.size()), 32'd0);
    chk("latches_drained", 32'(exp_latch), 32'd0);
    chk("reads_drained", 32'(rd_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
